bnn_fc_layer: RTL and testbench
===============================

Name: bnn_fc_layer

Overview:
Parametrised binary-weight fully connected layer for the BNN datapath. It is the multi-neuron successor of the single-output fc block. Serially loaded 1-bit weights select +x or -x for each signed input element. N_CH lanes are accepted per beat, and all N_OUT neuron sums accumulate in parallel. Results drain serially with index tagging, saturation and an argmax classification result. It sits after the last conv/pool stage and feeds the classifier output.

Parameters:
DIN_W, 32, signed input lane width
N_CH, 6, input lanes per beat
IN_LEN, 192, input elements per frame; must be a multiple of N_CH
N_OUT, 10, output neurons
ACC_W, 48, accumulator width; must be >= DIN_W + clog2(IN_LEN) + 1
DOUT_W, 32, output width; saturated from ACC_W

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
weight  in  1  serial weight bit; 1 = +x, 0 = -x
weight_en  in  1  weight bit strobe
wclr  in  1  abort any operation and restart weight load
ivalid  in  1  input beat valid
din  in  N_CH*DIN_W  packed signed lanes; lane c at [c*DIN_W +: DIN_W]
in_ready  out  1  beat accepted when ivalid & in_ready
wload_done  out  1  weight memory full
ovalid  out  1  dout valid
dout  out  DOUT_W  signed saturated neuron sum
oidx  out  clog2(N_OUT)  neuron index of dout
olast  out  1  high with the last neuron of a frame
class_valid  out  1  one-cycle pulse with olast
class_idx  out  clog2(N_OUT)  argmax neuron index

Behaviour:
- Reset: every output is 0, state is S_WLOAD, all counters and accumulators are 0. Weight memory contents are don't-care.
- Interface decision: one clock; reset is asynchronous and active-low.
- State S_WLOAD:
  - Each cycle with weight_en=1 stores weight at bit index wcnt, then increments wcnt.
  - Bit index n*IN_LEN + j is the weight of neuron n for input element j.
  - When the bit at index N_OUT*IN_LEN-1 is stored, wcnt clears, wload_done goes to 1 and the next state is S_ACC.
  - in_ready=0 in this state; ivalid is ignored.
- State S_ACC:
  - in_ready=1.
  - On an accepted beat b, element j = b*N_CH + c is taken from lane c.
  - Each acc[n] adds sum over c of (w[n][j] ? +din_c : -din_c), sign-extended to ACC_W.
  - The lane sum and the accumulate complete in one cycle.
  - weight_en is ignored in this state.
  - The beat counter runs 0..IN_LEN/N_CH-1. On accepting the last beat, the next state is S_DRAIN.
- State S_DRAIN:
  - in_ready=0. ivalid is ignored, and no data is lost-tracked; the upstream holds.
  - The first cycle of S_DRAIN immediately follows the clock edge that captured the last beat.
  - For k = 0..N_OUT-1 on consecutive cycles: ovalid=1, oidx=k, dout=sat(acc[k]).
  - sat clamps to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1].
  - olast=1 when k=N_OUT-1.
  - In the same cycle as olast: class_valid=1 and class_idx = index of the maximum unsaturated acc. Ties resolve to the lowest index.
  - A running max and its index are tracked during the drain. They are compared on full ACC_W values.
  - After the olast cycle, all acc clear to 0 and the next state is S_ACC. Outputs are registered.
- Latency:
  - Last beat edge to first ovalid: 1 cycle.
  - Frame period: IN_LEN/N_CH accepted beats + N_OUT drain cycles.
  - ivalid may be continuous or gapped.
- wclr:
  - Synchronous, highest priority, accepted in any state.
  - Next state is S_WLOAD. wload_done=0, acc cleared, counters cleared.
  - ovalid/olast/class_valid go to 0 from the next cycle.
  - A partial frame is discarded.
- Reset mid-frame or mid-drain: immediate return to reset values; weights must be reloaded.
- weight_en together with wclr: wclr wins and the bit is discarded.

Test Plan:
1. Default params. Load 1920 bits all 1; 32 beats of all lanes = 1 -> ten outputs of 192, oidx 0..9, olast on idx 9. class_idx=0 (tie, lowest index) with class_valid.
2. Weights all 0; lanes = 3 -> every dout = -576.
3. Neuron n weight = 1 for j < 20n, else 0; lanes = 1 -> dout[n] = 40n - 192. class_idx=9 (value 168).
4. DIN_W=32, lanes = 0x7FFFFFFF, all weights 1 -> acc = 192*(2^31-1). dout saturates to 2147483647, and class_idx=0.
5. ivalid held high through the drain -> in_ready=0 during the 10 drain cycles. The next frame's first beat is accepted on the cycle after olast, and the frame-2 result equals the standalone result.
6. Assert wclr after 15 beats, reload weights, and send a full frame -> no ovalid from the aborted frame; new results are correct. Assert rstn low mid-drain -> all outputs 0 and wload_done=0.

Source files
------------

// File: rtl/bnn_fc_layer.sv
// Binary-weight fully connected layer: serial 1-bit weight load, N_OUT parallel
// accumulators fed N_CH lanes per beat, serial saturated drain with argmax.
module bnn_fc_layer #(
    parameter int DIN_W  = 32,
    parameter int N_CH   = 6,
    parameter int IN_LEN = 192,
    parameter int N_OUT  = 10,
    parameter int ACC_W  = 48,
    parameter int DOUT_W = 32,
    localparam int OIDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     weight,
    input  logic                     weight_en,
    input  logic                     wclr,
    input  logic                     ivalid,
    input  logic [N_CH*DIN_W-1:0]    din,
    output logic                     in_ready,
    output logic                     wload_done,
    output logic                     ovalid,
    output logic signed [DOUT_W-1:0] dout,
    output logic [OIDX_W-1:0]        oidx,
    output logic                     olast,
    output logic                     class_valid,
    output logic [OIDX_W-1:0]        class_idx
);
    localparam int N_BEATS = IN_LEN / N_CH;
    localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int LANE_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_CH - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);
    localparam logic [OIDX_W-1:0] LAST_OUT  = OIDX_W'(N_OUT - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

    typedef enum logic [1:0] {S_WLOAD, S_ACC, S_DRAIN} state_e;

    state_e                   state_q, state_d;
    logic [OIDX_W-1:0]        wn_q, wn_d;
    logic [BEAT_W-1:0]        wb_q, wb_d;
    logic [LANE_W-1:0]        wc_q, wc_d;
    logic [BEAT_W-1:0]        bcnt_q, bcnt_d;
    logic [OIDX_W-1:0]        dcnt_q, dcnt_d;
    logic signed [ACC_W-1:0]  acc_q [N_OUT];
    logic signed [ACC_W-1:0]  acc_d [N_OUT];
    logic signed [ACC_W-1:0]  max_q, max_d;
    logic [OIDX_W-1:0]        midx_q, midx_d;
    logic                     wload_done_q, wload_done_d;
    logic                     ovalid_q, ovalid_d;
    logic signed [DOUT_W-1:0] dout_q, dout_d;
    logic [OIDX_W-1:0]        oidx_q, oidx_d;
    logic                     olast_q, olast_d;
    logic                     class_valid_q, class_valid_d;
    logic [OIDX_W-1:0]        class_idx_q, class_idx_d;

    // Weight bit (n, beat, lane) is flat bit index n*IN_LEN + beat*N_CH + lane.
    logic [N_CH-1:0]          wmem_q [N_OUT][N_BEATS];

    logic signed [ACC_W-1:0]  lane_ext [N_CH];
    logic signed [ACC_W-1:0]  beat_sum [N_OUT];
    logic                     ld_en;
    logic [OIDX_W-1:0]        ld_idx;
    logic signed [ACC_W-1:0]  ld_val;

    function automatic logic signed [DOUT_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[DOUT_W-1:0];
        if (v < SAT_MIN) return SAT_MIN[DOUT_W-1:0];
        return v[DOUT_W-1:0];
    endfunction

    // NOTE: weight storage has no reset; it is always fully rewritten before use.
    always_ff @(posedge clk) begin
        if (state_q == S_WLOAD && weight_en && !wclr)
            wmem_q[wn_q][wb_q][wc_q] <= weight;
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++)
            lane_ext[c] = ACC_W'($signed(din[c*DIN_W +: DIN_W]));
        for (int n = 0; n < N_OUT; n++) begin
            beat_sum[n] = '0;
            for (int c = 0; c < N_CH; c++)
                beat_sum[n] = wmem_q[n][bcnt_q][c] ? beat_sum[n] + lane_ext[c]
                                                   : beat_sum[n] - lane_ext[c];
        end
    end

    // NOTE: every variable gets a default first so no path through this block infers a latch.
    always_comb begin
        state_d       = state_q;
        wn_d          = wn_q;
        wb_d          = wb_q;
        wc_d          = wc_q;
        bcnt_d        = bcnt_q;
        dcnt_d        = dcnt_q;
        acc_d         = acc_q;
        max_d         = max_q;
        midx_d        = midx_q;
        wload_done_d  = wload_done_q;
        ovalid_d      = 1'b0;
        dout_d        = '0;
        oidx_d        = '0;
        olast_d       = 1'b0;
        class_valid_d = 1'b0;
        class_idx_d   = '0;
        ld_en         = 1'b0;
        ld_idx        = '0;
        ld_val        = '0;

        case (state_q)
            S_WLOAD: begin
                if (weight_en) begin
                    if (wc_q == LAST_LANE) begin
                        wc_d = '0;
                        if (wb_q == LAST_BEAT) begin
                            wb_d = '0;
                            if (wn_q == LAST_OUT) begin
                                wn_d         = '0;
                                wload_done_d = 1'b1;
                                state_d      = S_ACC;
                            end else begin
                                wn_d = wn_q + 1'b1;
                            end
                        end else begin
                            wb_d = wb_q + 1'b1;
                        end
                    end else begin
                        wc_d = wc_q + 1'b1;
                    end
                end
            end
            S_ACC: begin
                if (ivalid) begin
                    for (int n = 0; n < N_OUT; n++)
                        acc_d[n] = acc_q[n] + beat_sum[n];
                    if (bcnt_q == LAST_BEAT) begin
                        // Present neuron 0 straight from the final sum so it is valid one edge later.
                        bcnt_d  = '0;
                        dcnt_d  = '0;
                        state_d = S_DRAIN;
                        ld_en   = 1'b1;
                        ld_val  = acc_d[0];
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (dcnt_q == LAST_OUT) begin
                    state_d = S_ACC;
                    dcnt_d  = '0;
                    for (int n = 0; n < N_OUT; n++)
                        acc_d[n] = '0;
                end else begin
                    ld_en  = 1'b1;
                    ld_idx = dcnt_q + 1'b1;
                    ld_val = acc_q[ld_idx];
                    dcnt_d = ld_idx;
                end
            end
            default: state_d = S_WLOAD;
        endcase

        if (ld_en) begin
            ovalid_d = 1'b1;
            oidx_d   = ld_idx;
            dout_d   = sat(ld_val);
            olast_d  = (ld_idx == LAST_OUT);
            // Strict greater-than keeps the lowest index on ties.
            if (ld_idx == '0 || ld_val > max_q) begin
                max_d  = ld_val;
                midx_d = ld_idx;
            end
            if (olast_d) begin
                class_valid_d = 1'b1;
                class_idx_d   = midx_d;
            end
        end

        if (wclr) begin
            state_d       = S_WLOAD;
            wn_d          = '0;
            wb_d          = '0;
            wc_d          = '0;
            bcnt_d        = '0;
            dcnt_d        = '0;
            for (int n = 0; n < N_OUT; n++)
                acc_d[n] = '0;
            max_d         = '0;
            midx_d        = '0;
            wload_done_d  = 1'b0;
            ovalid_d      = 1'b0;
            dout_d        = '0;
            oidx_d        = '0;
            olast_d       = 1'b0;
            class_valid_d = 1'b0;
            class_idx_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_WLOAD;
            wn_q          <= '0;
            wb_q          <= '0;
            wc_q          <= '0;
            bcnt_q        <= '0;
            dcnt_q        <= '0;
            for (int n = 0; n < N_OUT; n++)
                acc_q[n] <= '0;
            max_q         <= '0;
            midx_q        <= '0;
            wload_done_q  <= 1'b0;
            ovalid_q      <= 1'b0;
            dout_q        <= '0;
            oidx_q        <= '0;
            olast_q       <= 1'b0;
            class_valid_q <= 1'b0;
            class_idx_q   <= '0;
        end else begin
            state_q       <= state_d;
            wn_q          <= wn_d;
            wb_q          <= wb_d;
            wc_q          <= wc_d;
            bcnt_q        <= bcnt_d;
            dcnt_q        <= dcnt_d;
            acc_q         <= acc_d;
            max_q         <= max_d;
            midx_q        <= midx_d;
            wload_done_q  <= wload_done_d;
            ovalid_q      <= ovalid_d;
            dout_q        <= dout_d;
            oidx_q        <= oidx_d;
            olast_q       <= olast_d;
            class_valid_q <= class_valid_d;
            class_idx_q   <= class_idx_d;
        end
    end

    assign in_ready    = (state_q == S_ACC);
    assign wload_done  = wload_done_q;
    assign ovalid      = ovalid_q;
    assign dout        = dout_q;
    assign oidx        = oidx_q;
    assign olast       = olast_q;
    assign class_valid = class_valid_q;
    assign class_idx   = class_idx_q;

endmodule

// File: tb/tb_bnn_fc_layer.sv
// Directed self-checking bench for bnn_fc_layer at default parameters.
module tb_bnn_fc_layer;
    localparam int DIN_W   = 32;
    localparam int N_CH    = 6;
    localparam int IN_LEN  = 192;
    localparam int N_OUT   = 10;
    localparam int ACC_W   = 48;
    localparam int DOUT_W  = 32;
    localparam int N_BEATS = IN_LEN / N_CH;
    localparam int OIDX_W  = $clog2(N_OUT);

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic weight = 1'b0, weight_en = 1'b0, wclr = 1'b0, ivalid = 1'b0;
    logic [N_CH*DIN_W-1:0] din = '0;
    logic in_ready, wload_done, ovalid, olast, class_valid;
    logic signed [DOUT_W-1:0] dout;
    logic [OIDX_W-1:0] oidx, class_idx;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bnn_fc_layer #(
        .DIN_W(DIN_W), .N_CH(N_CH), .IN_LEN(IN_LEN),
        .N_OUT(N_OUT), .ACC_W(ACC_W), .DOUT_W(DOUT_W)
    ) dut (
        .clk(clk), .rstn(rstn), .weight(weight), .weight_en(weight_en), .wclr(wclr),
        .ivalid(ivalid), .din(din), .in_ready(in_ready), .wload_done(wload_done),
        .ovalid(ovalid), .dout(dout), .oidx(oidx), .olast(olast),
        .class_valid(class_valid), .class_idx(class_idx)
    );

    // Weight patterns: 0 = all +x, 1 = all -x, 2 = neuron n is +x for j < 20n.
    function automatic bit wbit(input int mode, input int n, input int j);
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            default: return (j < 20 * n);
        endcase
    endfunction

    function automatic longint model_acc(input int mode, input longint lane, input int n);
        longint s = 0;
        for (int j = 0; j < IN_LEN; j++)
            s += wbit(mode, n, j) ? lane : -lane;
        return s;
    endfunction

    function automatic longint sat_ref(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    task automatic pulse_wclr();
        @(negedge clk);
        wclr = 1'b1;
        @(negedge clk);
        wclr = 1'b0;
    endtask

    task automatic load_weights(input int mode);
        for (int i = 0; i < N_OUT * IN_LEN; i++) begin
            @(negedge clk);
            weight    = wbit(mode, i / IN_LEN, i % IN_LEN);
            weight_en = 1'b1;
        end
        @(negedge clk);
        weight_en = 1'b0;
        weight    = 1'b0;
        vectors++;
        if (wload_done !== 1'b1) begin
            miscompares++;
            $display("FAIL wload_done_mode%0d: got %0b expected 1", mode, wload_done);
        end
    endtask

    // Sends one frame of identical lanes and checks every drain cycle against the model.
    task automatic run_frame(input int mode, input longint lane, input bit hold, input string tag);
        logic [DIN_W-1:0] lv;
        longint a [N_OUT];
        int best = 0;
        lv = lane[DIN_W-1:0];
        for (int n = 0; n < N_OUT; n++) begin
            a[n] = model_acc(mode, lane, n);
            if (a[n] > a[best]) best = n;
        end
        for (int b = 0; b < N_BEATS; b++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL %s_ready_beat%0d: got %0b expected 1", tag, b, in_ready);
            end
            ivalid = 1'b1;
            din    = {N_CH{lv}};
        end
        for (int k = 0; k < N_OUT; k++) begin
            @(negedge clk);
            if (!hold) ivalid = 1'b0;
            vectors++;
            if (ovalid !== 1'b1 || oidx !== OIDX_W'(k) || dout !== sat_ref(a[k]) ||
                olast !== (k == N_OUT - 1) || in_ready !== 1'b0 ||
                class_valid !== (k == N_OUT - 1)) begin
                miscompares++;
                $display("FAIL %s_out%0d: ovalid=%0b oidx=%0d dout=%0d olast=%0b in_ready=%0b class_valid=%0b; expected 1 %0d %0d %0b 0 %0b",
                         tag, k, ovalid, oidx, dout, olast, in_ready, class_valid,
                         k, sat_ref(a[k]), k == N_OUT - 1, k == N_OUT - 1);
            end
        end
        vectors++;
        if (class_idx !== OIDX_W'(best)) begin
            miscompares++;
            $display("FAIL %s_class_idx: got %0d expected %0d", tag, class_idx, best);
        end
        if (!hold) begin
            @(negedge clk);
            vectors++;
            if (ovalid !== 1'b0 || class_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL %s_after_drain: ovalid=%0b class_valid=%0b in_ready=%0b; expected 0 0 1",
                         tag, ovalid, class_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        @(negedge clk);
        vectors++;
        if ({in_ready, wload_done, ovalid, olast, class_valid} !== 5'b0 || dout !== '0 ||
            oidx !== '0 || class_idx !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%0b done=%0b ovalid=%0b olast=%0b cv=%0b dout=%0d oidx=%0d cidx=%0d; expected all 0",
                     in_ready, wload_done, ovalid, olast, class_valid, dout, oidx, class_idx);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || wload_done !== 1'b0 || ovalid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ready=%0b done=%0b ovalid=%0b; expected 0 0 0",
                     in_ready, wload_done, ovalid);
        end
    endtask

    task automatic test_all_ones();
        load_weights(0);
        run_frame(0, 64'sd1, 1'b0, "all_ones");
    endtask

    task automatic test_back_to_back();
        run_frame(0, 64'sd1, 1'b1, "b2b_f1");
        run_frame(0, 64'sd1, 1'b0, "b2b_f2");
    endtask

    task automatic test_saturation();
        run_frame(0, 64'sd2147483647, 1'b0, "sat_pos");
        pulse_wclr();
        load_weights(1);
        run_frame(1, 64'sd3, 1'b0, "all_neg");
        run_frame(1, 64'sd2147483647, 1'b0, "sat_neg");
    endtask

    task automatic test_staircase();
        pulse_wclr();
        load_weights(2);
        run_frame(2, 64'sd1, 1'b0, "staircase");
    endtask

    task automatic test_wclr_abort();
        int seen = 0;
        for (int b = 0; b < 15; b++) begin
            @(negedge clk);
            ivalid = 1'b1;
            din    = {N_CH{32'd5}};
        end
        @(negedge clk);
        wclr      = 1'b1;
        weight_en = 1'b1;
        weight    = 1'b0;
        @(negedge clk);
        wclr      = 1'b0;
        weight_en = 1'b0;
        ivalid    = 1'b0;
        vectors++;
        if (wload_done !== 1'b0 || in_ready !== 1'b0 || ovalid !== 1'b0) begin
            miscompares++;
            $display("FAIL wclr_state: done=%0b ready=%0b ovalid=%0b; expected 0 0 0",
                     wload_done, in_ready, ovalid);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ovalid) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL wclr_no_ovalid: got %0d ovalid cycles expected 0", seen);
        end
        load_weights(0);
        run_frame(0, 64'sd1, 1'b0, "after_wclr");
    endtask

    task automatic test_reset_mid_drain();
        for (int b = 0; b < N_BEATS; b++) begin
            @(negedge clk);
            ivalid = 1'b1;
            din    = {N_CH{32'd2}};
        end
        @(negedge clk);
        ivalid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (ovalid !== 1'b1 || oidx !== OIDX_W'(3) || dout !== 32'sd384) begin
            miscompares++;
            $display("FAIL mid_drain_out3: ovalid=%0b oidx=%0d dout=%0d; expected 1 3 384",
                     ovalid, oidx, dout);
        end
        rstn = 1'b0;
        #1;
        vectors++;
        if ({in_ready, wload_done, ovalid, olast, class_valid} !== 5'b0 || dout !== '0 ||
            oidx !== '0 || class_idx !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_drain: ready=%0b done=%0b ovalid=%0b olast=%0b cv=%0b dout=%0d oidx=%0d; expected all 0",
                     in_ready, wload_done, ovalid, olast, class_valid, dout, oidx);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || wload_done !== 1'b0 || ovalid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_release_wload: ready=%0b done=%0b ovalid=%0b; expected 0 0 0",
                     in_ready, wload_done, ovalid);
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_back_to_back();
        test_saturation();
        test_staircase();
        test_wclr_abort();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
